// File: rtl/ntt_out_reorder_pkg.sv
// Shared defaults, buffer geometry and FSM encoding for the NTT output reorder buffer.
package ntt_out_reorder_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_MAX_DEPTH = 10;
  localparam int unsigned BRAM_DEPTH    = 1 << DEF_MAX_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/ntt_out_reorder_if.sv
// Control, input stream and output stream of the reorder buffer; slave is the buffer side.
interface ntt_out_reorder_if
  import ntt_out_reorder_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              start;
  logic [DATA_W-1:0] q;
  logic [3:0]        ring_depth;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              frame_done;
  logic              overflow;

  modport master (
    output start, q, ring_depth, din_valid, din, dout_ready,
    input  dout, dout_valid, busy, frame_done, overflow
  );

  modport slave (
    input  start, q, ring_depth, din_valid, din, dout_ready,
    output dout, dout_valid, busy, frame_done, overflow
  );

endinterface

// File: rtl/ntt_out_reorder_bram.sv
// Simple dual-port buffer RAM with a one-cycle registered read; contents are never reset.
module reorder_bram
  import ntt_out_reorder_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_MAX_DEPTH,
  parameter int unsigned DEPTH  = BRAM_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register only advances on i_re so the caller can hold a word across stalls.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ntt_out_reorder.sv
// Collects one interleaved NTT output frame, reduces each word mod q, and drains it in natural order.
module ntt_out_reorder
  import ntt_out_reorder_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_DEPTH = DEF_MAX_DEPTH
) (
  input  logic               i_clk,
  input  logic               i_reset,
  ntt_out_reorder_if.slave   bus
);

  localparam int unsigned AW = MAX_DEPTH;
  localparam int unsigned CW = MAX_DEPTH + 1;
  localparam logic [3:0]  DEPTH_CAP = 4'(MAX_DEPTH);

  state_t            r_state;
  logic [DATA_W-1:0] r_q;
  logic [3:0]        r_depth;
  logic [CW-1:0]     r_wcnt;
  logic [CW-1:0]     r_rcnt;
  logic [CW-1:0]     r_ocnt;
  logic              r_rvalid;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_overflow;

  logic [CW-1:0]     w_n;
  logic [CW-1:0]     w_half;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_re;
  logic [AW-1:0]     w_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_hs;
  logic              w_last_in;
  logic              w_last_out;

  assign w_n    = CW'(1) << r_depth;
  assign w_half = w_n >> 1;

  // Even words fill the lower half, odd words the upper half.
  assign w_we      = (r_state == S_COLLECT) && bus.din_valid;
  assign w_waddr   = AW'(r_wcnt >> 1) + (r_wcnt[0] ? AW'(w_half) : '0);
  assign w_wdata   = (bus.din >= r_q) ? (bus.din - r_q) : bus.din;
  assign w_last_in = (r_wcnt == (w_n - CW'(1)));

  // The RAM read register doubles as the output holding stage: a new read is
  // issued only when that stage is empty or is being emptied this cycle.
  assign w_hs       = r_rvalid && bus.dout_ready;
  assign w_re       = (r_state == S_DRAIN) && (r_rcnt < w_n) && (!r_rvalid || bus.dout_ready);
  assign w_raddr    = AW'(r_rcnt);
  assign w_last_out = (r_ocnt == (w_n - CW'(1)));

  reorder_bram #(
    .DATA_W (DATA_W),
    .ADDR_W (AW),
    .DEPTH  (1 << MAX_DEPTH)
  ) u_bram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_q          <= '0;
      r_depth      <= '0;
      r_wcnt       <= '0;
      r_rcnt       <= '0;
      r_ocnt       <= '0;
      r_rvalid     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_re) begin
        r_rvalid <= 1'b1;
      end else if (w_hs) begin
        r_rvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_q        <= bus.q;
            r_depth    <= (bus.ring_depth > DEPTH_CAP) ? DEPTH_CAP : bus.ring_depth;
            r_wcnt     <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (bus.din_valid) begin
            r_wcnt <= r_wcnt + CW'(1);
            if (w_last_in) begin
              r_rcnt  <= '0;
              r_ocnt  <= '0;
              r_state <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (bus.din_valid) begin
            r_overflow <= 1'b1;
          end
          if (w_re) begin
            r_rcnt <= r_rcnt + CW'(1);
          end
          if (w_hs) begin
            r_ocnt <= r_ocnt + CW'(1);
            if (w_last_out) begin
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = r_rvalid ? w_rdata : '0;
  assign bus.dout_valid = r_rvalid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_ntt_out_reorder.sv
// Directed scoreboard bench for ntt_out_reorder: reorder, reduction, stalls, overflow, reset.
module tb_ntt_out_reorder;

  localparam int unsigned DW = 32;
  localparam logic [31:0] QV = 32'd515694593;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ntt_out_reorder_if #(.DATA_W(DW)) bus ();

  ntt_out_reorder #(
    .DATA_W    (DW),
    .MAX_DEPTH (10)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          fd_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem[1024];
  int          m_idx;
  int          cur_n;
  logic [31:0] cur_q;
  bit          use_model;
  logic        pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input logic [31:0] qv, input logic [3:0] depth);
    bus.q          = qv;
    bus.ring_depth = depth;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    cur_q     = qv;
    cur_n     = 1 << depth;
    m_idx     = 0;
  endtask

  // Expected frame is built as words are driven and queued once the frame is complete.
  task automatic feed(input logic [31:0] v, input int gap);
    int a;
    bus.din_valid = 1'b1;
    bus.din       = v;
    if (use_model) begin
      a = (m_idx % 2 == 0) ? (m_idx / 2) : (m_idx / 2 + cur_n / 2);
      model_mem[a] = (v >= cur_q) ? (v - cur_q) : v;
    end
    m_idx++;
    if (use_model && m_idx == cur_n) begin
      for (int k = 0; k < cur_n; k++) exp_q.push_back(model_mem[k]);
    end
    tick();
    bus.din_valid = 1'b0;
    bus.din       = '0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input bit toggle, input int budget);
    int cyc  = 0;
    bit seen = 1'b0;
    while (!seen && cyc < budget) begin
      bus.dout_ready = toggle ? pat[cyc % 4] : 1'b1;
      tick();
      cyc++;
      if (bus.frame_done) seen = 1'b1;
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
    bus.dout_ready = 1'b1;
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"},       bus.dout,       32'd0);
    chk({tag, "_dout_valid"}, bus.dout_valid, 32'd0);
    chk({tag, "_busy"},       bus.busy,       32'd0);
    chk({tag, "_frame_done"}, bus.frame_done, 32'd0);
    chk({tag, "_overflow"},   bus.overflow,   32'd0);
  endtask

  logic        prev_stall = 1'b0;
  logic [31:0] prev_dout  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.frame_done) fd_count++;
      if (prev_stall) begin
        chk("stall_valid_held", bus.dout_valid, 32'd1);
        chk("stall_dout_held",  bus.dout,       prev_dout);
      end
      if (!bus.dout_valid) begin
        chk("dout_zero_when_invalid", bus.dout, 32'd0);
      end else if (bus.dout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", bus.dout_valid, 32'd0);
        else                   chk("dout_data", bus.dout, exp_q.pop_front());
      end
      prev_stall = bus.dout_valid && !bus.dout_ready;
      prev_dout  = bus.dout;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          vcnt;
    int          fdb;
    longint      lv;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.q          = '0;
    bus.ring_depth = '0;
    bus.din_valid  = 1'b0;
    bus.din        = '0;
    bus.dout_ready = 1'b1;
    use_model      = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Full 1024-point frame, expected values written directly from the closed form.
    begin_frame(QV, 4'd10);
    chk("busy_after_start", bus.busy, 32'd1);
    for (int k = 0; k < 1024; k++)
      exp_q.push_back((k < 512) ? 32'(2 * k + 1) : 32'(2 * (k - 512) + 2));
    for (int m = 0; m < 1024; m++) feed(32'(m + 1), 0);
    chk("latency_cycle1_valid", bus.dout_valid, 32'd0);
    tick();
    chk("latency_cycle2_valid", bus.dout_valid, 32'd1);
    fdb  = fd_count;
    vcnt = 0;
    for (int i = 0; i < 1024; i++) begin
      if (bus.dout_valid) vcnt++;
      tick();
    end
    chk("contiguous_valids", vcnt, 32'd1024);
    chk("frame_done_pulse", bus.frame_done, 32'd1);
    chk("busy_after_frame", bus.busy, 32'd0);
    tick();
    chk("frame_done_once", fd_count - fdb, 32'd1);
    chk("frame_done_cleared", bus.frame_done, 32'd0);
    chk("queue_drained_f1", exp_q.size(), 32'd0);

    // Reduction boundaries: q+5 -> 5, q-1 kept, q -> 0.
    use_model = 1'b1;
    begin_frame(QV, 4'd10);
    feed(QV + 32'd5, 0);
    feed(QV - 32'd1, 0);
    feed(QV, 0);
    for (int m = 3; m < 1024; m++) feed(32'(m + 1), 0);
    wait_done(1'b0, 3000);

    // Smallest ring with a stalling consumer.
    begin_frame(QV, 4'd4);
    for (int m = 0; m < 16; m++) feed(QV / 2 + 32'(m * 32'h0111_1111), 0);
    wait_done(1'b1, 200);

    // IDLE input is ignored; gapped frame; extra word in DRAIN raises overflow.
    for (int i = 0; i < 3; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 32'hDEAD_BEEF;
      tick();
      bus.din_valid = 1'b0;
      tick();
    end
    chk("idle_din_busy", bus.busy, 32'd0);
    chk("idle_din_overflow", bus.overflow, 32'd0);
    chk("idle_din_valid", bus.dout_valid, 32'd0);
    begin_frame(QV, 4'd10);
    for (int m = 0; m < 1024; m++) begin
      lv = (longint'(m) * 64'd2654435761) % (2 * longint'(QV));
      feed(32'(lv), m % 3);
    end
    bus.din_valid = 1'b1;
    bus.din       = 32'h1234_5678;
    tick();
    bus.din_valid = 1'b0;
    tick();
    chk("overflow_set", bus.overflow, 32'd1);
    wait_done(1'b0, 3000);
    chk("overflow_sticky", bus.overflow, 32'd1);

    // Start clears overflow; a second start mid-frame must not relatch or restart.
    begin_frame(QV, 4'd4);
    chk("overflow_cleared_by_start", bus.overflow, 32'd0);
    for (int m = 0; m < 5; m++) feed(32'(m * 1000 + 7), 0);
    bus.q          = 32'd7;
    bus.ring_depth = 4'd5;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_during_restart", bus.busy, 32'd1);
    for (int m = 5; m < 16; m++) feed(32'(m * 1000 + 7), 0);
    wait_done(1'b1, 200);

    // Asynchronous reset mid-COLLECT, then a clean frame.
    begin_frame(QV, 4'd10);
    for (int m = 0; m < 300; m++) feed(32'(m + 100), 0);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    chk_all_zero("reset_edge");
    rst = 1'b0;
    tick();
    chk("no_residue_queued", exp_q.size(), 32'd0);
    begin_frame(QV, 4'd10);
    for (int m = 0; m < 1024; m++) feed(QV + 32'(m * 13), 0);
    wait_done(1'b0, 3000);
    chk("post_reset_idle_valid", bus.dout_valid, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
